genius_seq_player: RTL and testbench

//   Sequence store and playback stage of the Genius game, directly upstream of the
//   4-way 4-bit LED pattern mux. Appends pseudo-random 2-bit colours to an internal

---
 rtl/genius_seq_player_pkg.sv | 31 +++
 rtl/genius_lfsr8.sv | 32 +++
 rtl/genius_seq_player.sv | 169 ++++++++++++++++
 tb/tb_genius_seq_player.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/genius_seq_player_pkg.sv
// -----------------------------------------------------------------------------
// genius_seq_player_pkg
//   Shared definitions for the Genius sequence stages: FSM state encodings,
//   colour indices, the LFSR seed and the LFSR next-state function.
// -----------------------------------------------------------------------------
package genius_seq_player_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Colour indices, matching the input order of the LED pattern mux
  localparam logic [1:0] COL_GREEN  = 2'd0;
  localparam logic [1:0] COL_RED    = 2'd1;
  localparam logic [1:0] COL_BLUE   = 2'd2;
  localparam logic [1:0] COL_YELLOW = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting left.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/genius_lfsr8.sv
// -----------------------------------------------------------------------------
// genius_lfsr8
//   Free-running 8-bit pseudo-random source shared by the game stages.
//   Ports:
//     CLOCK  in   clock, rising edge
//     RESET  in   synchronous active-high reset, loads LFSR_SEED
//     q      out  current LFSR state
// -----------------------------------------------------------------------------
module genius_lfsr8
  import genius_seq_player_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESET,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = lfsr8_next(lfsr_q);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/genius_seq_player.sv
// -----------------------------------------------------------------------------
// genius_seq_player
//   Stores a sequence of random 2-bit colours and replays it with fixed lamp
//   on/off timing, driving the select of the downstream LED pattern mux.
//   Ports:
//     CLOCK   in   clock, rising edge
//     RESET   in   synchronous active-high reset (clears sequence, aborts play)
//     ADD     in   pulse: append one random colour (IDLE only, ignored if FULL)
//     START   in   pulse: replay entries 0..LEN-1 (IDLE only, wins over ADD)
//     SEL     out  colour shown, 0 when dark
//     LED_EN  out  lamp enable
//     BUSY    out  high while showing or in a gap
//     DONE    out  one-cycle pulse at the end of a playback
//     FULL    out  LEN == MAX_LEN
//     LEN     out  number of stored entries
//   All outputs are registered from the current state, so they trail the state
//   register by one cycle: START sampled at edge t gives LED_EN from edge t+1.
// -----------------------------------------------------------------------------
module genius_seq_player
  import genius_seq_player_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         ADD,
  input  logic                         START,
  output logic [1:0]                   SEL,
  output logic                         LED_EN,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         FULL,
  output logic [$clog2(MAX_LEN+1)-1:0] LEN
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(max2(ON_TICKS, OFF_TICKS) + 1);

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  logic [7:0]       lfsr_w;
  logic             unused_lfsr_hi;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [1:0]       mem_q [MAX_LEN];
  logic             wr_en;
  logic             full;
  logic             last_entry;

  logic [1:0]       sel_q,  sel_d;
  logic             led_q,  led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  genius_lfsr8 u_lfsr (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .q     (lfsr_w)
  );

  // Only the two low bits form a colour; the rest feed the LFSR itself.
  assign unused_lfsr_hi = ^lfsr_w[7:2];

  assign full = (len_q == LEN_MAX);

  // Only consulted in GAP, which is reachable only with len_q >= 1.
  assign last_entry = (LEN_W'(idx_q) == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = (len_q != '0) ? ST_SHOW : ST_FIN;
        end else if (ADD && !full) begin
          wr_en = 1'b1;
          len_d = len_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (last_entry) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SHOW;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_FIN: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_d  = (state_q == ST_SHOW) ? mem_q[idx_q] : 2'd0;
    led_d  = (state_q == ST_SHOW);
    busy_d = (state_q == ST_SHOW) || (state_q == ST_GAP);
    done_d = (state_q == ST_FIN);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      // Colour is the LFSR value present in the cycle ADD is seen.
      if (wr_en) begin
        mem_q[len_q[IDX_W-1:0]] <= lfsr_w[1:0];
      end
    end
  end

  assign SEL    = sel_q;
  assign LED_EN = led_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign FULL   = full;
  assign LEN    = len_q;

endmodule

// File: tb/tb_genius_seq_player.sv
module tb_genius_seq_player;

  localparam int MAX_LEN   = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       ADD   = 1'b0;
  logic       START = 1'b0;
  logic [1:0] SEL;
  logic       LED_EN;
  logic       BUSY;
  logic       DONE;
  logic       FULL;
  logic [2:0] LEN;

  genius_seq_player #(
    .MAX_LEN   (MAX_LEN),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ADD    (ADD),
    .START  (START),
    .SEL    (SEL),
    .LED_EN (LED_EN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .FULL   (FULL),
    .LEN    (LEN)
  );

  always #5 CLOCK = ~CLOCK;

  int         total  = 0;
  int         passed = 0;
  logic [7:0] lfsr_m;
  logic [1:0] mem_m [MAX_LEN];
  int         len_m  = 0;
  logic [4:0] exp_q [$];   // {SEL, LED_EN, BUSY, DONE} per cycle

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the reference model follows the edge, then outputs settle.
  task automatic tick(input bit accept);
    @(posedge CLOCK);
    if (RESET) begin
      lfsr_m = 8'hA5;
      len_m  = 0;
      for (int i = 0; i < MAX_LEN; i++) mem_m[i] = 2'd0;
    end else begin
      if (accept) begin
        mem_m[len_m] = lfsr_m[1:0];
        len_m++;
      end
      lfsr_m = ref_step(lfsr_m);
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; ADD = 1'b0; START = 1'b0;
    tick(0);
    tick(0);
    RESET = 1'b0;
  endtask

  task automatic add_one(input string tag);
    bit acc;
    acc = (len_m < MAX_LEN);
    ADD = 1'b1;
    tick(acc);
    ADD = 1'b0;
    tick(0);
    check({tag, " LEN"},  {5'd0, LEN}, 8'(len_m));
    check({tag, " FULL"}, {7'd0, FULL}, {7'd0, (len_m == MAX_LEN)});
  endtask

  task automatic push_play(input int n);
    exp_q.push_back(5'b00_000);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ON_TICKS; k++)  exp_q.push_back({mem_m[i], 3'b110});
      for (int k = 0; k < OFF_TICKS; k++) exp_q.push_back(5'b00_010);
    end
    exp_q.push_back(5'b00_001);
    exp_q.push_back(5'b00_000);
  endtask

  // START pulse (optionally with ADD), then per-cycle scoreboard compare.
  // add_at: cycle at which ADD and START are pulsed again while busy (-1: never).
  task automatic play(input string tag, input int n, input int max_pops,
                      input bit with_add, input int add_at);
    logic [4:0] e;
    push_play(n);
    START = 1'b1;
    ADD   = with_add;
    tick(0);
    START = 1'b0;
    ADD   = 1'b0;
    for (int c = 0; c < max_pops && exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      check($sformatf("%s cyc%0d", tag, c), {3'd0, SEL, LED_EN, BUSY, DONE}, {3'd0, e});
      if (c + 1 < max_pops && exp_q.size() > 0) begin
        if (c == add_at) begin
          ADD = 1'b1;
          START = 1'b1;
        end
        tick(0);
        ADD = 1'b0;
        START = 1'b0;
      end
    end
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst SEL",    {6'd0, SEL},    8'd0);
    check("rst LED_EN", {7'd0, LED_EN}, 8'd0);
    check("rst BUSY",   {7'd0, BUSY},   8'd0);
    check("rst DONE",   {7'd0, DONE},   8'd0);
    check("rst LEN",    {5'd0, LEN},    8'd0);
    check("rst FULL",   {7'd0, FULL},   8'd0);

    // Three ADDs, then replay
    add_one("t1 add0");
    add_one("t1 add1");
    add_one("t1 add2");
    play("t2 play3", 3, 100, 0, -1);
    check("t2 LEN after", {5'd0, LEN}, 8'd3);

    // Fill past capacity, then replay all four
    do_reset();
    for (int i = 0; i < 5; i++) add_one($sformatf("t3 add%0d", i));
    play("t3 play4", 4, 100, 0, -1);

    // Empty playback
    do_reset();
    play("t4 play0", 0, 100, 0, -1);
    check("t4 LEN", {5'd0, LEN}, 8'd0);

    // START with ADD in the same cycle; ADD/START during playback
    do_reset();
    add_one("t5 add0");
    add_one("t5 add1");
    play("t5 play2", 2, 100, 1, 5);
    check("t5 LEN after", {5'd0, LEN}, 8'd2);

    // Reset during the show of entry 1
    play("t6 play2", 2, 7, 0, -1);
    RESET = 1'b1;
    tick(0);
    RESET = 1'b0;
    check("t6 LED_EN", {7'd0, LED_EN}, 8'd0);
    check("t6 SEL",    {6'd0, SEL},    8'd0);
    check("t6 LEN",    {5'd0, LEN},    8'd0);
    check("t6 BUSY",   {7'd0, BUSY},   8'd0);
    check("t6 DONE",   {7'd0, DONE},   8'd0);
    for (int i = 0; i < 4; i++) begin
      tick(0);
      check($sformatf("t6 post%0d", i), {5'd0, LED_EN, BUSY, DONE}, 8'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
